// File: rtl/header_lookup_queue_pkg.sv
// rtl/header_lookup_queue_pkg.sv - shared widths, register map, FSM codes and hash helper
package header_lookup_queue_pkg;

    localparam int OF_HEADER_REG_WIDTH = 96;
    localparam int UDP_REG_ADDR_WIDTH  = 23;
    localparam int CPCI_NF2_DATA_WIDTH = 32;
    localparam int LKQ_HASH_WIDTH      = 16;

    // Register address = {block tag, word offset}
    localparam int LKQ_WORD_ADDR_BITS = 4;
    localparam int LKQ_TAG_BITS       = UDP_REG_ADDR_WIDTH - LKQ_WORD_ADDR_BITS;
    localparam logic [LKQ_TAG_BITS-1:0] LKQ_BLOCK_ADDR = 19'h02A5C;

    localparam logic [LKQ_WORD_ADDR_BITS-1:0] LKQ_DROP_CNT_WORD  = 4'd0;
    localparam logic [LKQ_WORD_ADDR_BITS-1:0] LKQ_CAP_CNT_WORD   = 4'd1;
    localparam logic [LKQ_WORD_ADDR_BITS-1:0] LKQ_OCCUPANCY_WORD = 4'd2;
    localparam logic [LKQ_WORD_ADDR_BITS-1:0] LKQ_STATE_WORD     = 4'd3;
    localparam logic [CPCI_NF2_DATA_WIDTH-1:0] LKQ_UNUSED_DATA   = 32'hDEADBEEF;

    // Number of 64-bit words the hash walks over, and the counter that indexes them
    localparam int LKQ_NUM_WORDS = (OF_HEADER_REG_WIDTH + 63) / 64;
    localparam int LKQ_WC_WIDTH  = (LKQ_NUM_WORDS > 1) ? $clog2(LKQ_NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        LKQ_IDLE    = 2'd0,
        LKQ_HASH    = 2'd1,
        LKQ_PRESENT = 2'd2
    } lkq_state_e;

    function automatic logic [LKQ_HASH_WIDTH-1:0] lkq_fold64(input logic [63:0] word);
        return word[15:0] ^ word[31:16] ^ word[47:32] ^ word[63:48];
    endfunction

endpackage

// File: rtl/header_fifo.sv
// rtl/header_fifo.sv - parameterised FIFO holding captured headers
// Ports: clk/reset (sync, active-high); push_i/push_data_i write side (a push
// on a full FIFO is accepted only together with a pop); pop_i/pop_data_o read
// side (pop_data_o is the current head, valid while !empty_o); full_o, empty_o,
// count_o occupancy.
module header_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A full FIFO can still take a push when the head leaves in the same cycle
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/header_lookup_queue.sv
// rtl/header_lookup_queue.sv - queues parsed headers, hashes them and presents them to lookup
// Ports: clk/reset (sync, active-high); header_bus/headers_valid from the
// header parser (rising edge of headers_valid captures); lookup_req/
// lookup_header/lookup_hash/lookup_ack lookup handshake; reg_*_in/reg_*_out
// register chain (status words: drop count, capture count, occupancy, state).
module header_lookup_queue
    import header_lookup_queue_pkg::*;
#(
    parameter int FIFO_DEPTH        = 4,
    parameter int UDP_REG_SRC_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [OF_HEADER_REG_WIDTH-1:0]  header_bus,
    input  logic                            headers_valid,
    output logic                            lookup_req,
    output logic [OF_HEADER_REG_WIDTH-1:0]  lookup_header,
    output logic [LKQ_HASH_WIDTH-1:0]       lookup_hash,
    input  logic                            lookup_ack,
    input  logic                            reg_req_in,
    input  logic                            reg_ack_in,
    input  logic                            reg_rd_wr_L_in,
    input  logic [UDP_REG_ADDR_WIDTH-1:0]   reg_addr_in,
    input  logic [CPCI_NF2_DATA_WIDTH-1:0]  reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in,
    output logic                            reg_req_out,
    output logic                            reg_ack_out,
    output logic                            reg_rd_wr_L_out,
    output logic [UDP_REG_ADDR_WIDTH-1:0]   reg_addr_out,
    output logic [CPCI_NF2_DATA_WIDTH-1:0]  reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out
);
    localparam int W     = OF_HEADER_REG_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LKQ_WC_WIDTH-1:0] LAST_WORD = LKQ_WC_WIDTH'(LKQ_NUM_WORDS - 1);

    lkq_state_e                     state_q, state_d;
    logic [W-1:0]                   work_q, work_d;
    logic [LKQ_HASH_WIDTH-1:0]      acc_q, acc_d;
    logic [LKQ_WC_WIDTH-1:0]        wc_q, wc_d;
    logic                           hv_q;
    logic [31:0]                    drop_cnt_q;
    logic [31:0]                    cap_cnt_q;

    logic                           fifo_pop;
    logic [W-1:0]                   fifo_data;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [CNT_W-1:0]               fifo_count;
    logic                           capture;
    logic                           drop;
    logic [LKQ_NUM_WORDS*64-1:0]    padded;
    logic [63:0]                    cur_word;

    // Only the 0->1 transition of headers_valid is a new header
    assign capture = headers_valid && !hv_q;
    assign drop    = capture && fifo_full && !fifo_pop;

    header_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (capture),
        .push_data_i (header_bus),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Work register zero-padded to whole 64-bit words; wc_q selects one per cycle
    always_comb begin
        padded        = '0;
        padded[W-1:0] = work_q;
        cur_word      = padded[{wc_q, 6'b0} +: 64];
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        acc_d    = acc_q;
        wc_d     = wc_q;
        fifo_pop = 1'b0;
        case (state_q)
            LKQ_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    work_d   = fifo_data;
                    acc_d    = '0;
                    wc_d     = '0;
                    state_d  = LKQ_HASH;
                end
            end
            LKQ_HASH: begin
                acc_d = acc_q ^ lkq_fold64(cur_word);
                if (wc_q == LAST_WORD) state_d = LKQ_PRESENT;
                else                   wc_d    = wc_q + 1'b1;
            end
            LKQ_PRESENT: begin
                if (lookup_ack) state_d = LKQ_IDLE;
            end
            default: state_d = LKQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LKQ_IDLE;
            work_q     <= '0;
            acc_q      <= '0;
            wc_q       <= '0;
            hv_q       <= 1'b1;
            drop_cnt_q <= '0;
            cap_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            acc_q   <= acc_d;
            wc_q    <= wc_d;
            hv_q    <= headers_valid;
            if (drop && drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
            if (capture && !drop)                    cap_cnt_q  <= cap_cnt_q + 1'b1;
        end
    end

    assign lookup_req    = (state_q == LKQ_PRESENT);
    assign lookup_header = work_q;
    assign lookup_hash   = acc_q;

    // Register chain
    logic                            reg_hit;
    logic [CPCI_NF2_DATA_WIDTH-1:0]  rd_data;
    logic                            reg_req_q, reg_ack_q, reg_rd_wr_L_q;
    logic [UDP_REG_ADDR_WIDTH-1:0]   reg_addr_q;
    logic [CPCI_NF2_DATA_WIDTH-1:0]  reg_data_q;
    logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_q;

    assign reg_hit = reg_req_in &&
                     (reg_addr_in[UDP_REG_ADDR_WIDTH-1:LKQ_WORD_ADDR_BITS] == LKQ_BLOCK_ADDR);

    always_comb begin
        rd_data = LKQ_UNUSED_DATA;
        case (reg_addr_in[LKQ_WORD_ADDR_BITS-1:0])
            LKQ_DROP_CNT_WORD:  rd_data = drop_cnt_q;
            LKQ_CAP_CNT_WORD:   rd_data = cap_cnt_q;
            LKQ_OCCUPANCY_WORD: rd_data = CPCI_NF2_DATA_WIDTH'(fifo_count);
            LKQ_STATE_WORD:     rd_data = CPCI_NF2_DATA_WIDTH'(state_q);
            default:            rd_data = LKQ_UNUSED_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_req_q      <= 1'b0;
            reg_ack_q      <= 1'b0;
            reg_rd_wr_L_q  <= 1'b0;
            reg_addr_q     <= '0;
            reg_data_q     <= '0;
            reg_src_q      <= '0;
        end else begin
            reg_req_q     <= reg_req_in;
            reg_rd_wr_L_q <= reg_rd_wr_L_in;
            reg_addr_q    <= reg_addr_in;
            reg_src_q     <= reg_src_in;
            if (reg_hit) begin
                // Writes into this block are acknowledged but change nothing
                reg_ack_q  <= 1'b1;
                reg_data_q <= reg_rd_wr_L_in ? rd_data : reg_data_in;
            end else begin
                reg_ack_q  <= reg_ack_in;
                reg_data_q <= reg_data_in;
            end
        end
    end

    assign reg_req_out     = reg_req_q;
    assign reg_ack_out     = reg_ack_q;
    assign reg_rd_wr_L_out = reg_rd_wr_L_q;
    assign reg_addr_out    = reg_addr_q;
    assign reg_data_out    = reg_data_q;
    assign reg_src_out     = reg_src_q;

endmodule

// File: tb/tb_header_lookup_queue.sv
// tb/tb_header_lookup_queue.sv - directed self-checking bench for header_lookup_queue
module tb_header_lookup_queue;

    localparam logic [18:0] BLK   = 19'h02A5C;
    localparam logic [18:0] OTHER = 19'h00001;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] header_bus;
    logic        headers_valid;
    logic        lookup_req;
    logic [95:0] lookup_header;
    logic [15:0] lookup_hash;
    logic        lookup_ack;
    logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [22:0] reg_addr_in;
    logic [31:0] reg_data_in;
    logic [1:0]  reg_src_in;
    logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [22:0] reg_addr_out;
    logic [31:0] reg_data_out;
    logic [1:0]  reg_src_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    header_lookup_queue #(.FIFO_DEPTH(4), .UDP_REG_SRC_WIDTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .header_bus      (header_bus),
        .headers_valid   (headers_valid),
        .lookup_req      (lookup_req),
        .lookup_header   (lookup_header),
        .lookup_hash     (lookup_hash),
        .lookup_ack      (lookup_ack),
        .reg_req_in      (reg_req_in),
        .reg_ack_in      (reg_ack_in),
        .reg_rd_wr_L_in  (reg_rd_wr_L_in),
        .reg_addr_in     (reg_addr_in),
        .reg_data_in     (reg_data_in),
        .reg_src_in      (reg_src_in),
        .reg_req_out     (reg_req_out),
        .reg_ack_out     (reg_ack_out),
        .reg_rd_wr_L_out (reg_rd_wr_L_out),
        .reg_addr_out    (reg_addr_out),
        .reg_data_out    (reg_data_out),
        .reg_src_out     (reg_src_out)
    );

    task automatic expect_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic [95:0] hdr);
        @(negedge clk);
        header_bus    = hdr;
        headers_valid = 1'b1;
        @(negedge clk);
        headers_valid = 1'b0;
    endtask

    task automatic reg_rw(input logic rd, input logic [18:0] blk, input logic [3:0] word,
                          input logic [31:0] wdata, input logic ack_in,
                          output logic [31:0] data, output logic ack);
        @(negedge clk);
        reg_req_in     = 1'b1;
        reg_rd_wr_L_in = rd;
        reg_addr_in    = {blk, word};
        reg_data_in    = wdata;
        reg_ack_in     = ack_in;
        @(negedge clk);
        data = reg_data_out;
        ack  = reg_ack_out;
        reg_req_in  = 1'b0;
        reg_ack_in  = 1'b0;
        reg_data_in = 32'h0;
    endtask

    task automatic read_word(input string tag, input logic [3:0] word, input logic [31:0] exp);
        logic [31:0] d;
        logic        a;
        reg_rw(1'b1, BLK, word, 32'h0, 1'b0, d, a);
        expect_eq({tag, "_ack"}, a, 1'b1);
        expect_eq(tag, d, exp);
    endtask

    logic [95:0] hq [6];
    logic [95:0] got [8];
    int          cyc, nreq, got_n;
    logic [31:0] rd;
    logic        ra;

    initial begin
        reset = 1'b1; header_bus = 96'hFFFF; headers_valid = 1'b1; lookup_ack = 1'b0;
        reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b1;
        reg_addr_in = '0; reg_data_in = '0; reg_src_in = 2'b10;

        // Reset state, with headers_valid high throughout reset
        repeat (3) @(negedge clk);
        expect_eq("rst_req",     lookup_req, 1'b0);
        expect_eq("rst_header",  lookup_header, 96'h0);
        expect_eq("rst_hash",    lookup_hash, 16'h0);
        expect_eq("rst_reg_req", reg_req_out, 1'b0);
        expect_eq("rst_reg_ack", reg_ack_out, 1'b0);
        expect_eq("rst_reg_dat", reg_data_out, 32'h0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        expect_eq("no_cap_after_rst_req", lookup_req, 1'b0);
        headers_valid = 1'b0;
        read_word("rst_cap_cnt", 4'd1, 32'd0);

        // Single header, ack held high: latency, hash, exactly one request
        lookup_ack = 1'b1;
        @(negedge clk);
        header_bus    = 96'h1234;
        headers_valid = 1'b1;
        cyc = 0;
        while (!lookup_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        expect_eq("latency", cyc, 4);
        expect_eq("hash_1234", lookup_hash, 16'h1234);
        expect_eq("hdr_1234", lookup_header, 96'h1234);
        nreq = 0;
        for (int i = 0; i < 30; i++) begin
            if (lookup_req) nreq++;
            @(negedge clk);
        end
        expect_eq("one_request", nreq, 1);
        headers_valid = 1'b0;

        // Hash folding across two 64-bit words
        @(negedge clk);
        header_bus    = {16'h0, 16'h1000, 32'h0, 16'h00FF, 16'h1234};
        headers_valid = 1'b1;
        cyc = 0;
        while (!lookup_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        expect_eq("hash_02cb_seen", lookup_req, 1'b1);
        expect_eq("hash_02cb", lookup_hash, 16'h02CB);
        headers_valid = 1'b0;
        repeat (5) @(negedge clk);

        // Overflow: six headers, no ack
        do_reset();
        lookup_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            hq[i] = {32'hC0DE0000 + i, 32'h0, 32'h100 + i};
            pulse(hq[i]);
            repeat (4) @(negedge clk);
        end
        expect_eq("ovf_req", lookup_req, 1'b1);
        expect_eq("ovf_head", lookup_header, hq[0]);
        read_word("ovf_drop", 4'd0, 32'd1);
        read_word("ovf_cap",  4'd1, 32'd5);
        read_word("ovf_occ",  4'd2, 32'd4);
        read_word("ovf_state", 4'd3, 32'd2);
        read_word("unused_w7", 4'd7, 32'hDEADBEEF);
        reg_rw(1'b0, BLK, 4'd0, 32'h55, 1'b0, rd, ra);
        expect_eq("write_ack", ra, 1'b1);
        read_word("drop_after_write", 4'd0, 32'd1);

        // Foreign tag: everything passes through one cycle later
        reg_rw(1'b1, OTHER, 4'd0, 32'hCAFEF00D, 1'b1, rd, ra);
        expect_eq("pass_ack",  ra, 1'b1);
        expect_eq("pass_data", rd, 32'hCAFEF00D);
        expect_eq("pass_addr", reg_addr_out, {OTHER, 4'd0});
        expect_eq("pass_req",  reg_req_out, 1'b1);
        expect_eq("pass_src",  reg_src_out, 2'b10);
        reg_rw(1'b1, OTHER, 4'd1, 32'h0BADF00D, 1'b0, rd, ra);
        expect_eq("pass_noack", ra, 1'b0);
        expect_eq("pass_data2", rd, 32'h0BADF00D);

        // Release ack: five requests in capture order
        got_n = 0;
        lookup_ack = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (lookup_req) begin
                if (got_n < 8) got[got_n] = lookup_header;
                got_n++;
            end
            @(negedge clk);
        end
        expect_eq("drain_count", got_n, 5);
        for (int j = 0; j < 5; j++) expect_eq($sformatf("drain_%0d", j), got[j], hq[j]);
        read_word("drain_occ", 4'd2, 32'd0);

        // Level-high headers_valid for 100 cycles captures once
        do_reset();
        lookup_ack = 1'b1;
        @(negedge clk);
        header_bus    = 96'hABCD;
        headers_valid = 1'b1;
        repeat (100) @(negedge clk);
        headers_valid = 1'b0;
        repeat (10) @(negedge clk);
        read_word("level_cap", 4'd1, 32'd1);

        // Reset while presenting with two headers queued
        do_reset();
        lookup_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse(96'h500 + i);
            repeat (4) @(negedge clk);
        end
        expect_eq("pre_rst_req", lookup_req, 1'b1);
        read_word("pre_rst_occ", 4'd2, 32'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        expect_eq("mid_rst_req", lookup_req, 1'b0);
        reset = 1'b0;
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            if (lookup_req) nreq++;
            @(negedge clk);
        end
        expect_eq("post_rst_reqs", nreq, 0);
        read_word("post_rst_occ", 4'd2, 32'd0);
        read_word("post_rst_state", 4'd3, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
